// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of a 4-lane FP adder between two requesters with credit-bounded response FIFOs
module fp_add_arbiter #(
  parameter int EXP_BITS = 5,
  parameter int MANT_BITS = 6,
  parameter int ADD_LAT = 2,
  parameter int DEPTH = 4,
  localparam int W = 1 + EXP_BITS + MANT_BITS,
  localparam int VW = 4 * W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [VW-1:0] req_x0,
  input  logic [VW-1:0] req_y0,
  input  logic [VW-1:0] req_x1,
  input  logic [VW-1:0] req_y1,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [VW-1:0] rsp_data0,
  output logic [VW-1:0] rsp_data1,
  output logic          add_in_valid,
  output logic [VW-1:0] add_x,
  output logic [VW-1:0] add_y,
  input  logic          add_out_valid,
  input  logic [VW-1:0] add_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [CW-1:0] cnt [2];
  logic [CW-1:0] occ [2];
  logic [PW-1:0] wp [2];
  logic [PW-1:0] rp [2];
  logic [VW-1:0] mem [2][DEPTH];
  logic last_grant, add_tag;
  logic [ADD_LAT-1:0] pv, pt;
  logic [1:0] elig, gnt, pop, push;
  // eligibility, round-robin grant and FIFO strobes; a write is accepted only when the tag pipeline vouches for it
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      elig[i] = req_valid[i] && cnt[i] < CW'(DEPTH);
      push[i] = add_out_valid && pv[ADD_LAT-1] && pt[ADD_LAT-1] == 1'(i);
      rsp_valid[i] = occ[i] != '0;
    end
    gnt = rst ? 2'b00 : &elig ? (last_grant ? 2'b01 : 2'b10) : elig;
    req_ready = gnt;
    pop = rsp_valid & rsp_ready;
    rsp_data0 = rsp_valid[0] ? mem[0][rp[0]] : '0;
    rsp_data1 = rsp_valid[1] ? mem[1][rp[1]] : '0;
  end
  // issue register, tag pipeline, credit counters and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      add_in_valid <= 1'b0;
      add_x <= '0;
      add_y <= '0;
      add_tag <= 1'b0;
      last_grant <= 1'b1;
      pv <= '0;
      pt <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
        occ[i] <= '0;
        wp[i] <= '0;
        rp[i] <= '0;
      end
    end else begin
      add_in_valid <= |gnt;
      if (|gnt) begin
        add_x <= gnt[1] ? req_x1 : req_x0;
        add_y <= gnt[1] ? req_y1 : req_y0;
        add_tag <= gnt[1];
        last_grant <= gnt[1];
      end
      pv <= ADD_LAT'({pv, add_in_valid});
      pt <= ADD_LAT'({pt, add_tag});
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= cnt[i] + CW'(gnt[i]) - CW'(pop[i]);
        occ[i] <= occ[i] + CW'(push[i]) - CW'(pop[i]);
        if (push[i]) wp[i] <= wp[i] + PW'(1);
        if (pop[i]) rp[i] <= rp[i] + PW'(1);
      end
    end
  end
  // FIFO storage is left unreset since the head is masked while empty
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push[i]) mem[i][wp[i]] <= add_out;
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb_fp_add_arbiter: randomized and directed checks of fp_add_arbiter against a queue-based reference model
module tb_fp_add_arbiter;
  localparam int E = 5, M = 6, LAT = 2, D = 4, W = 12, VW = 48;
  logic clk = 0, rst = 1;
  logic [1:0] req_valid = 0, req_ready, rsp_valid, rsp_ready = 0;
  logic [VW-1:0] req_x0 = 0, req_y0 = 0, req_x1 = 0, req_y1 = 0;
  logic [VW-1:0] rsp_data0, rsp_data1, add_x, add_y, add_out;
  logic add_in_valid, add_out_valid, spur = 0;
  logic [LAT-1:0] av = '0;
  logic [VW-1:0] ad [LAT];
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  fp_add_arbiter dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_x1(req_x1), .req_y1(req_y1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
    .add_in_valid(add_in_valid), .add_x(add_x), .add_y(add_y),
    .add_out_valid(add_out_valid), .add_out(add_out));
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // positive-normal FP add with truncation, enough for the operands this bench generates
  function automatic logic [W-1:0] fadd(logic [W-1:0] a, logic [W-1:0] b);
    int ea, eb, d;
    logic [M+1:0] ma, mb, s;
    ea = int'(a[W-2:M]);
    eb = int'(b[W-2:M]);
    ma = {2'b01, a[M-1:0]};
    mb = {2'b01, b[M-1:0]};
    if (ea < eb) begin
      d = ea; ea = eb; eb = d;
      s = ma; ma = mb; mb = s;
    end
    d = ea - eb;
    mb = (d > M + 1) ? '0 : mb >> d;
    s = ma + mb;
    if (s[M+1]) begin
      s = s >> 1;
      ea++;
    end
    return {1'b0, E'(ea), s[M-1:0]};
  endfunction
  function automatic logic [VW-1:0] vadd(logic [VW-1:0] x, logic [VW-1:0] y);
    logic [VW-1:0] r;
    for (int k = 0; k < 4; k++) r[k*W +: W] = fadd(x[k*W +: W], y[k*W +: W]);
    return r;
  endfunction
  function automatic logic [VW-1:0] rvec();
    logic [VW-1:0] v;
    for (int k = 0; k < 4; k++) v[k*W +: W] = {1'b0, E'(8 + $urandom_range(12)), M'($urandom)};
    return v;
  endfunction
  task automatic rand_ops();
    req_x0 = rvec(); req_y0 = rvec(); req_x1 = rvec(); req_y1 = rvec();
  endtask
  // external adder: fixed latency, not reset, plus an injectable untracked strobe
  always @(posedge clk) begin
    av <= LAT'({av, add_in_valid});
    ad[0] <= vadd(add_x, add_y);
    for (int k = 1; k < LAT; k++) ad[k] <= ad[k-1];
  end
  assign add_out_valid = av[LAT-1] | spur;
  assign add_out = spur ? '1 : ad[LAT-1];
  // reference model sampled just before each rising edge
  logic [VW-1:0] d0[$], d1[$];
  int t0[$], t1[$];
  int mcnt[2], cyc = 0;
  bit mlast = 1, armed = 0;
  logic [1:0] e, g, ev;
  always @(negedge clk) begin
    #4;
    if (rst) begin
      if (armed) check("rst_gate", req_ready, 2'b00);
      d0.delete(); d1.delete(); t0.delete(); t1.delete();
      mcnt[0] = 0; mcnt[1] = 0; mlast = 1; armed = 1;
    end else if (armed) begin
      e[0] = req_valid[0] && mcnt[0] < D;
      e[1] = req_valid[1] && mcnt[1] < D;
      g = (&e) ? (mlast ? 2'b01 : 2'b10) : e;
      ev[0] = d0.size() > 0 && t0[0] <= cyc;
      ev[1] = d1.size() > 0 && t1[0] <= cyc;
      check("grant", req_ready, g);
      check("rsp_valid", rsp_valid, ev);
      if (ev[0]) check("rsp_data0", rsp_data0, d0[0]);
      if (ev[1]) check("rsp_data1", rsp_data1, d1[0]);
      if (ev[0] && rsp_ready[0]) begin void'(d0.pop_front()); void'(t0.pop_front()); mcnt[0]--; end
      if (ev[1] && rsp_ready[1]) begin void'(d1.pop_front()); void'(t1.pop_front()); mcnt[1]--; end
      if (g[0]) begin d0.push_back(vadd(req_x0, req_y0)); t0.push_back(cyc + LAT + 2); mcnt[0]++; end
      if (g[1]) begin d1.push_back(vadd(req_x1, req_y1)); t1.push_back(cyc + LAT + 2); mcnt[1]++; end
      if (|g) mlast = g[1];
    end
    cyc++;
  end
  int gc, g0, g1;
  logic [VW-1:0] v2;
  initial begin
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_aiv", add_in_valid, 0);
    check("rst_add_x", add_x, 0);
    check("rst_add_y", add_y, 0);
    check("rst_rspv", rsp_valid, 0);
    check("rst_data0", rsp_data0, 0);
    check("rst_data1", rsp_data1, 0);
    rst = 0; req_valid = 0; rsp_ready = 2'b11;
    @(negedge clk);
    req_valid = 2'b01; req_x0 = {4{12'h3C0}}; req_y0 = {4{12'h3C0}};
    #1 check("single_rdy", req_ready, 2'b01);
    @(negedge clk); req_valid = 0;
    #1 check("single_issue", add_in_valid, 1);
    repeat (2) @(negedge clk);
    #1 check("single_early", rsp_valid, 0);
    @(negedge clk);
    #1 check("single_rspv", rsp_valid, 2'b01);
    check("single_data", rsp_data0, {4{12'h400}});
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 2'b11; rand_ops();
      #1 check("rr_grant", req_ready, (c % 2) ? 2'b10 : 2'b01);
      @(negedge clk);
    end
    req_valid = 0;
    repeat (8) @(negedge clk);
    rsp_ready = 2'b10; req_valid = 2'b01; gc = 0;
    repeat (12) begin
      rand_ops();
      #1 gc += int'(req_ready[0]);
      @(negedge clk);
    end
    check("bp_grants", gc, 4);
    #1 check("bp_blocked", req_ready[0], 0);
    rsp_ready = 2'b11;
    #1 gc += int'(req_ready[0]);
    @(negedge clk); rsp_ready = 2'b10;
    repeat (8) begin
      #1 gc += int'(req_ready[0]);
      @(negedge clk);
    end
    check("bp_one_more", gc, 5);
    req_valid = 2'b11; g0 = 0; g1 = 0;
    repeat (8) begin
      rand_ops();
      #1 g0 += int'(req_ready[0]); g1 += int'(req_ready[1]);
      @(negedge clk);
    end
    check("iso_r0", g0, 0);
    check("iso_r1", g1 >= 6, 1);
    req_valid = 0; rsp_ready = 2'b11;
    repeat (12) @(negedge clk);
    spur = 1;
    @(negedge clk); spur = 0;
    #1 check("spur", rsp_valid, 0);
    @(negedge clk);
    #1 check("spur_late", rsp_valid, 0);
    rsp_ready = 0; req_valid = 2'b01; rand_ops();
    @(negedge clk); rand_ops(); v2 = vadd(req_x0, req_y0);
    @(negedge clk); req_valid = 0;
    repeat (2) @(negedge clk);
    #1 check("pp_occ_before", rsp_valid, 2'b01);
    rsp_ready = 2'b01;
    @(negedge clk); rsp_ready = 0;
    #1 check("pp_occ_after", rsp_valid, 2'b01);
    check("pp_head", rsp_data0, v2);
    rsp_ready = 2'b01;
    @(negedge clk); rsp_ready = 0;
    #1 check("pp_empty", rsp_valid, 0);
    req_valid = 2'b01; rand_ops();
    @(negedge clk); req_valid = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    #1 check("mr_rspv", rsp_valid, 0);
    check("mr_aiv", add_in_valid, 0);
    repeat (3) begin
      @(negedge clk);
      #1 check("mr_late", rsp_valid, 0);
    end
    req_valid = 2'b01; gc = 0;
    repeat (6) begin
      rand_ops();
      #1 gc += int'(req_ready[0]);
      @(negedge clk);
    end
    check("mr_credits", gc, 4);
    req_valid = 0; rsp_ready = 2'b11;
    repeat (10) @(negedge clk);
    repeat (400) begin
      req_valid = 2'($urandom);
      rsp_ready = {$urandom_range(3) != 0, $urandom_range(3) != 0};
      rand_ops();
      @(negedge clk);
    end
    req_valid = 0; rsp_ready = 2'b11;
    repeat (20) @(negedge clk);
    check("drain_rspv", rsp_valid, 0);
    check("drain_model", d0.size() + d1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
